clk_div_sched: RTL and testbench

Multi-channel clock-divider scheduler for peripheral timing. It holds up to CHANNELS independent divided-clock generators that share one configuration write port. Each generator produces a 50%-duty divided clock and a single-cycle tick strobe. Divisor changes are staged in a shadow register and take effect only at a period boundary, so running outputs never glitch. The block sits between the SoC configuration logic and the peripherals that need slow sample clocks or enables.

---
 rtl/clk_div_sched.sv | 164 ++++++++++++++++
 tb/tb_clk_div_sched.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_sched.sv
// clk_div_sched -- multi-channel clock-divider scheduler.
//
// Each channel runs a divided clock with a 50% duty cycle and a one-cycle
// tick. The tick fires in the first clk_i cycle of each high phase. Divisor
// updates to a running channel are staged in a shadow register. They are
// applied only at a half-period wrap, so a running clock never glitches.
//
// Ports:
//   clk_i, rst_i    system clock and synchronous active-high reset
//   cfg_we_i        one-cycle configuration write strobe
//   cfg_ch_i        target channel; values >= CHANNELS are acked and dropped
//   cfg_half_i      new half-period minus one (H)
//   cfg_en_i        channel enable, written together with H
//   cfg_ack_o       high in the cycle after each accepted strobe
//   pending_o       per channel: a staged H is waiting for a wrap
//   clk_o           divided clocks, period 2*(H+1) clk_i cycles
//   tick_o          one-cycle strobe in the first high cycle of clk_o

// One divider channel. All outputs are flops.
module clk_div_chan #(
  parameter int COUNTER_WIDTH = 18,
  parameter int DEFAULT_HALF  = 3999
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [COUNTER_WIDTH-1:0] half_i,
  input  logic                     en_i,
  output logic                     clk_o,
  output logic                     tick_o,
  output logic                     pend_o
);
  localparam logic [COUNTER_WIDTH-1:0] DEF_H = COUNTER_WIDTH'(DEFAULT_HALF);

  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNTER_WIDTH-1:0] half_q, half_d;
  logic [COUNTER_WIDTH-1:0] shadow_q, shadow_d;
  logic pend_q, pend_d;
  logic en_q, en_d;
  logic clk_q, clk_d;
  logic tick_q, tick_d;

  always_comb begin
    cnt_d    = cnt_q;
    half_d   = half_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    en_d     = en_q;
    clk_d    = clk_q;
    tick_d   = 1'b0;

    // Free-running part: count up to half, then wrap and toggle. A staged
    // value is picked up only here, at a half-period boundary.
    if (en_q) begin
      if (cnt_q == half_q) begin
        cnt_d  = '0;
        clk_d  = ~clk_q;
        tick_d = ~clk_q;
        if (pend_q) begin
          half_d = shadow_q;
          pend_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + COUNTER_WIDTH'(1);
      end
    end else begin
      cnt_d = '0;
      clk_d = 1'b0;
    end

    // A write is evaluated after the wrap. A write landing on a wrap
    // therefore stages behind the shadow value that the wrap just consumed.
    if (we_i) begin
      en_d = en_i;
      if (!en_q) begin
        // Idle channel: nothing is running, so load the value directly.
        half_d = half_i;
      end else if (en_i) begin
        shadow_d = half_i;
        pend_d   = 1'b1;
      end else begin
        // Disable truncates the period and discards any staged value.
        cnt_d  = '0;
        clk_d  = 1'b0;
        tick_d = 1'b0;
        pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      half_q   <= DEF_H;
      shadow_q <= DEF_H;
      pend_q   <= 1'b0;
      en_q     <= 1'b0;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      half_q   <= half_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      en_q     <= en_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
    end
  end

  assign clk_o  = clk_q;
  assign tick_o = tick_q;
  assign pend_o = pend_q;
endmodule

module clk_div_sched #(
  parameter int CHANNELS      = 4,
  parameter int CH_W          = 2,
  parameter int COUNTER_WIDTH = 18,
  parameter int DEFAULT_HALF  = 3999
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cfg_we_i,
  input  logic [CH_W-1:0]          cfg_ch_i,
  input  logic [COUNTER_WIDTH-1:0] cfg_half_i,
  input  logic                     cfg_en_i,
  output logic                     cfg_ack_o,
  output logic [CHANNELS-1:0]      pending_o,
  output logic [CHANNELS-1:0]      clk_o,
  output logic [CHANNELS-1:0]      tick_o
);
  logic ack_q, ack_d;

  // Every strobe is acked, including writes to channels that do not exist.
  always_comb ack_d = cfg_we_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) ack_q <= 1'b0;
    else       ack_q <= ack_d;
  end

  assign cfg_ack_o = ack_q;

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    logic ch_we;
    // An out-of-range select matches no channel, so such a write is dropped.
    assign ch_we = cfg_we_i && (cfg_ch_i == CH_W'(n));

    clk_div_chan #(
      .COUNTER_WIDTH (COUNTER_WIDTH),
      .DEFAULT_HALF  (DEFAULT_HALF)
    ) u_ch (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .we_i   (ch_we),
      .half_i (cfg_half_i),
      .en_i   (cfg_en_i),
      .clk_o  (clk_o[n]),
      .tick_o (tick_o[n]),
      .pend_o (pending_o[n])
    );
  end
endmodule

// File: tb/tb_clk_div_sched.sv
// Testbench for clk_div_sched. The reference model tracks each channel as an
// output level and a countdown of the cycles left in the current half-phase.
module tb_clk_div_sched;
  localparam int CH  = 4;
  localparam int CHW = 3;
  localparam int CW  = 18;
  localparam int DH  = 3999;

  logic clk = 1'b0, rst = 1'b0, we = 1'b0, en = 1'b0;
  logic [CHW-1:0] ch = '0;
  logic [CW-1:0]  half = '0;
  logic ack;
  logic [CH-1:0] pend, clko, tick;

  clk_div_sched #(.CHANNELS(CH), .CH_W(CHW), .COUNTER_WIDTH(CW), .DEFAULT_HALF(DH)) dut (
    .clk_i(clk), .rst_i(rst), .cfg_we_i(we), .cfg_ch_i(ch), .cfg_half_i(half),
    .cfg_en_i(en), .cfg_ack_o(ack), .pending_o(pend), .clk_o(clko), .tick_o(tick));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  int m_left[CH], m_half[CH], m_shadow[CH];
  bit m_en[CH], m_pend[CH], m_lvl[CH], m_tick[CH];
  bit m_ack;

  function automatic logic [3*CH:0] exp_vec();
    logic [3*CH:0] v;
    v = '0;
    for (int i = 0; i < CH; i++) begin
      v[3*CH-CH+1+i] = m_lvl[i];
      v[CH+1+i]      = m_tick[i];
      v[1+i]         = m_pend[i];
    end
    v[0] = m_ack;
    return v;
  endfunction

  // Drive one cycle of inputs, clock it, and advance the reference model.
  task automatic step(input bit w, input int c, input int h, input bit e, input bit r);
    bit hit, was;
    we = w; ch = c[CHW-1:0]; half = h[CW-1:0]; en = e; rst = r;
    @(posedge clk);
    if (r) begin
      m_ack = 0;
      for (int i = 0; i < CH; i++) begin
        m_en[i] = 0; m_half[i] = DH; m_shadow[i] = DH;
        m_pend[i] = 0; m_lvl[i] = 0; m_tick[i] = 0; m_left[i] = DH + 1;
      end
    end else begin
      m_ack = w;
      for (int i = 0; i < CH; i++) begin
        hit = w && (c == i);
        was = m_en[i];
        m_tick[i] = 0;
        if (was) begin
          m_left[i]--;
          if (m_left[i] == 0) begin
            m_lvl[i]  = !m_lvl[i];
            m_tick[i] = m_lvl[i];
            if (m_pend[i]) begin m_half[i] = m_shadow[i]; m_pend[i] = 0; end
            m_left[i] = m_half[i] + 1;
          end
        end else m_lvl[i] = 0;
        if (hit) begin
          if (!was) begin
            m_half[i] = h; m_en[i] = e; m_left[i] = h + 1; m_lvl[i] = 0;
          end else if (e) begin
            m_shadow[i] = h; m_pend[i] = 1;
          end else begin
            m_en[i] = 0; m_lvl[i] = 0; m_tick[i] = 0; m_pend[i] = 0;
          end
        end
      end
    end
    #1;
    we = 0; rst = 0;
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    n_chk++;
    if ({clko, tick, pend, ack} !== '0)
      $display("FAIL reset outs act=%h exp=0", {clko, tick, pend, ack});
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 0);
      n_chk++;
      if ({clko, tick, pend, ack} !== '0)
        $display("FAIL reset_idle cyc%0d act=%h exp=0", k, {clko, tick, pend, ack});
      else n_pass++;
    end
  endtask

  task automatic test_basic();
    int last_tick, first_tick;
    last_tick = -1; first_tick = -1;
    step(1, 0, 3, 1, 0);
    n_chk++;
    if (ack !== 1'b1) $display("FAIL basic_ack act=%b exp=1", ack); else n_pass++;
    for (int k = 1; k <= 40; k++) begin
      step(0, 0, 0, 0, 0);
      n_chk++;
      if ({clko, tick, pend, ack} !== exp_vec())
        $display("FAIL basic cyc%0d act=%h exp=%h", k, {clko, tick, pend, ack}, exp_vec());
      else n_pass++;
      if (tick[0]) begin
        if (first_tick < 0) first_tick = k;
        if (last_tick >= 0) begin
          n_chk++;
          if (k - last_tick !== 8) $display("FAIL basic_tick_gap act=%0d exp=8", k - last_tick);
          else n_pass++;
        end
        last_tick = k;
      end
    end
    n_chk++;
    if (first_tick !== 4) $display("FAIL basic_first_tick act=%0d exp=4", first_tick);
    else n_pass++;
  endtask

  task automatic test_retime();
    int k, last_tog, prev;
    bit found;
    step(1, 1, 9, 1, 0);
    found = 0;
    for (k = 0; k < 40 && !found; k++) begin
      step(0, 0, 0, 0, 0);
      if (clko[1]) found = 1;
    end
    n_chk++;
    if (!found) $display("FAIL retime_rise_timeout act=0 exp=1"); else n_pass++;
    last_tog = 0;
    prev = clko[1];
    for (k = 1; k <= 3; k++) step(0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0);
    n_chk++;
    if (pend[1] !== 1'b1) $display("FAIL retime_pending act=%b exp=1", pend[1]); else n_pass++;
    for (k = 5; k <= 40; k++) begin
      step(0, 0, 0, 0, 0);
      n_chk++;
      if ({clko, tick, pend, ack} !== exp_vec())
        $display("FAIL retime cyc%0d act=%h exp=%h", k, {clko, tick, pend, ack}, exp_vec());
      else n_pass++;
      if (clko[1] != prev) begin
        n_chk++;
        if (k - last_tog < 2 || k - last_tog > 10)
          $display("FAIL retime_half_len act=%0d exp=2..10", k - last_tog);
        else n_pass++;
        last_tog = k;
        prev = clko[1];
      end
    end
    n_chk++;
    if (m_half[1] !== 1 || pend[1] !== 1'b0)
      $display("FAIL retime_final pend act=%b exp=0", pend[1]);
    else n_pass++;
  endtask

  task automatic test_h0();
    logic prev;
    step(1, 2, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    prev = clko[2];
    for (int k = 0; k < 12; k++) begin
      step(0, 0, 0, 0, 0);
      n_chk++;
      if (clko[2] !== ~prev || tick[2] !== clko[2])
        $display("FAIL h0_toggle cyc%0d act=%b%b exp=%b%b", k, clko[2], tick[2], ~prev, ~prev);
      else n_pass++;
      prev = clko[2];
    end
  endtask

  task automatic test_disable();
    int k;
    bit found;
    for (k = 0; k < 5; k++) step(0, 0, 0, 0, 0);
    step(1, 0, 5, 1, 0);
    step(1, 0, 7, 0, 0);
    n_chk++;
    if (clko[0] !== 1'b0 || pend[0] !== 1'b0 || tick[0] !== 1'b0)
      $display("FAIL disable act=clk%b pend%b exp=clk0 pend0", clko[0], pend[0]);
    else n_pass++;
    step(0, 0, 0, 0, 0);
    step(1, 0, 3, 1, 0);
    found = 0;
    for (k = 1; k <= 10 && !found; k++) begin
      step(0, 0, 0, 0, 0);
      if (clko[0]) begin
        found = 1;
        n_chk++;
        if (k !== 4) $display("FAIL reenable_rise act=%0d exp=4", k); else n_pass++;
      end
    end
    n_chk++;
    if (!found) $display("FAIL reenable_timeout act=0 exp=1"); else n_pass++;
  endtask

  task automatic test_wrap_write();
    int k;
    bit found;
    logic prev;
    step(1, 3, 2, 1, 0);
    step(1, 3, 4, 1, 0);
    found = 0;
    for (k = 0; k < 20 && !found; k++) begin
      if (m_left[3] == 1 && m_pend[3]) found = 1;
      else step(0, 0, 0, 0, 0);
    end
    n_chk++;
    if (!found) $display("FAIL wrapw_timeout act=0 exp=1"); else n_pass++;
    step(1, 3, 1, 1, 0);
    prev = clko[3];
    for (k = 1; k <= 5; k++) begin
      n_chk++;
      if (pend[3] !== 1'b1) $display("FAIL wrapw_pend cyc%0d act=%b exp=1", k, pend[3]);
      else n_pass++;
      step(0, 0, 0, 0, 0);
      if (k < 5) begin
        n_chk++;
        if (clko[3] !== prev) $display("FAIL wrapw_early_tog cyc%0d act=%b exp=%b", k, clko[3], prev);
        else n_pass++;
      end
    end
    n_chk++;
    if (clko[3] === prev || pend[3] !== 1'b0)
      $display("FAIL wrapw_apply act=clk%b pend%b exp=clk%b pend0", clko[3], pend[3], ~prev);
    else n_pass++;
    for (k = 0; k < 12; k++) begin
      step(0, 0, 0, 0, 0);
      n_chk++;
      if ({clko, tick, pend, ack} !== exp_vec())
        $display("FAIL wrapw cyc%0d act=%h exp=%h", k, {clko, tick, pend, ack}, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_bad_ch_reset();
    step(1, 4 + $urandom_range(0, 3), 1, 1, 0);
    n_chk++;
    if (ack !== 1'b1) $display("FAIL badch_ack act=%b exp=1", ack); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 0, 0, 0);
      n_chk++;
      if ({clko, tick, pend, ack} !== exp_vec())
        $display("FAIL badch cyc%0d act=%h exp=%h", k, {clko, tick, pend, ack}, exp_vec());
      else n_pass++;
    end
    step(1, 1, 2, 1, 1);
    n_chk++;
    if ({clko, tick, pend, ack} !== '0)
      $display("FAIL midreset act=%h exp=0", {clko, tick, pend, ack});
    else n_pass++;
    for (int k = 0; k < 12; k++) begin
      step(0, 0, 0, 0, 0);
      n_chk++;
      if (clko !== '0 || tick !== '0)
        $display("FAIL post_reset_idle cyc%0d act=%h exp=0", k, {clko, tick});
      else n_pass++;
    end
  endtask

  task automatic test_random();
    bit w, r;
    int c, h;
    bit e;
    for (int k = 0; k < 1500; k++) begin
      r = ($urandom_range(0, 299) == 0);
      w = !r && ($urandom_range(0, 9) == 0);
      c = $urandom_range(0, 7);
      h = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 7);
      e = ($urandom_range(0, 4) != 0);
      step(w, c, h, e, r);
      n_chk++;
      if ({clko, tick, pend, ack} !== exp_vec())
        $display("FAIL random cyc%0d act=%h exp=%h", k, {clko, tick, pend, ack}, exp_vec());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_retime();
    test_h0();
    test_disable();
    test_wrap_write();
    test_bad_ch_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
